// File: rtl/rl11_npr_pkg.sv
// Shared types and constants for the RL11 Unibus NPR (DMA) bus master.
// Holds the FSM state set, Unibus cycle codes and ARM register map.
package rl11_npr_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StGrant,
        StAddr,
        StMsyn,
        StLatch,
        StDrop,
        StFinish
    } npr_state_e;

    localparam logic [1:0] C_DATI  = 2'b00;
    localparam logic [1:0] C_DATO  = 2'b10;
    localparam logic [1:0] C_DATOB = 2'b11;

    localparam logic [31:0] IDVER_DEFAULT = 32'h444D2001;
    localparam logic [31:0] RD_UNMAPPED   = 32'hDEADBEEF;

    localparam logic [2:0] REG_ID   = 3'd0;
    localparam logic [2:0] REG_CSR  = 3'd1;
    localparam logic [2:0] REG_DATA = 3'd2;

    // Only byte writes may address an odd byte; word cycles force bit 0 low.
    function automatic logic [17:0] bus_addr(input logic [17:0] addr, input logic [1:0] c);
        return (c == C_DATOB) ? addr : {addr[17:1], 1'b0};
    endfunction

    // DATIP is run as a plain DATI.
    function automatic logic [1:0] bus_cycle(input logic [1:0] c);
        return (c == C_DATO || c == C_DATOB) ? c : C_DATI;
    endfunction

endpackage

// File: rtl/rl11_npr_master_if.sv
// Unibus signal bundle between the NPR master and the bus (arbiter, slaves).
// The master modport is the device side; the slave modport is the bus side.
interface rl11_npr_master_if;

    logic        init_in_h;
    logic        npg_in_h;
    logic        bbsy_in_h;
    logic        ssyn_in_h;
    logic [15:0] d_in_h;

    logic        npr_out_h;
    logic        sack_out_h;
    logic        bbsy_out_h;
    logic        msyn_out_h;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h;

    modport master (
        input  init_in_h,
        input  npg_in_h,
        input  bbsy_in_h,
        input  ssyn_in_h,
        input  d_in_h,
        output npr_out_h,
        output sack_out_h,
        output bbsy_out_h,
        output msyn_out_h,
        output a_out_h,
        output c_out_h,
        output d_out_h
    );

    modport slave (
        output init_in_h,
        output npg_in_h,
        output bbsy_in_h,
        output ssyn_in_h,
        output d_in_h,
        input  npr_out_h,
        input  sack_out_h,
        input  bbsy_out_h,
        input  msyn_out_h,
        input  a_out_h,
        input  c_out_h,
        input  d_out_h
    );

endinterface

// File: rtl/npr_timer.sv
// Saturating 16-bit state timer with deskew and timeout threshold flags.
// Cleared by the owner on every state entry; counts one per clock otherwise.
module npr_timer #(
    parameter int unsigned DESKEW  = 15,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic deskew_hit,
    output logic timeout_hit
);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign deskew_hit  = (count_q >= 16'(DESKEW));
    assign timeout_hit = (count_q >= 16'(TIMEOUT));

endmodule

// File: rtl/rl11_npr_master.sv
// Unibus NPR master for the RL11 disk path: the ARM side loads address, cycle
// code and write data, then this block arbitrates for the bus and runs one cycle.
module rl11_npr_master
    import rl11_npr_pkg::*;
#(
    parameter int unsigned DESKEW  = 15,
    parameter int unsigned TIMEOUT = 1000,
    parameter logic [31:0] IDVER   = IDVER_DEFAULT
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [2:0]  armraddr,
    input  logic [2:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    rl11_npr_master_if.master bus
);

    npr_state_e  state_q, state_d;
    logic [17:0] addr_q, addr_d;
    logic [1:0]  c_q, c_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        abort_q, abort_d;

    logic timer_clr, deskew_hit, timeout_hit;
    logic csr_wr, data_wr, is_write, on_bus;
    logic unused_wdata;

    assign unused_wdata = ^armwdata[30:20];

    assign is_write = (c_q == C_DATO) || (c_q == C_DATOB);
    assign on_bus   = (state_q == StAddr) || (state_q == StMsyn) ||
                      (state_q == StLatch) || (state_q == StDrop);

    // A start coinciding with INIT is dropped together with the rest of the write.
    assign csr_wr  = armwrite && (armwaddr == REG_CSR) && !busy_q && !bus.init_in_h;
    assign data_wr = armwrite && (armwaddr == REG_DATA) && !busy_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        c_d     = c_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        abort_d = abort_q;

        if (csr_wr) begin
            addr_d  = armwdata[17:0];
            c_d     = armwdata[19:18];
            done_d  = 1'b0;
            err_d   = 1'b0;
            abort_d = 1'b0;
            if (armwdata[31]) begin
                busy_d  = 1'b1;
                state_d = StReq;
            end
        end
        if (data_wr) begin
            wdata_d = armwdata[15:0];
        end

        case (state_q)
            StIdle: ;
            StReq: begin
                if (bus.npg_in_h) begin
                    state_d = StGrant;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end
            end
            StGrant: begin
                if (!bus.npg_in_h && !bus.bbsy_in_h && !bus.ssyn_in_h) begin
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (deskew_hit) begin
                    state_d = StMsyn;
                end
            end
            StMsyn: begin
                if (bus.ssyn_in_h) begin
                    if (!is_write) begin
                        rdata_d = bus.d_in_h;
                    end
                    state_d = StLatch;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDrop;
                end
            end
            StLatch: state_d = StDrop;
            StDrop: begin
                if ((!bus.ssyn_in_h || err_q) && deskew_hit) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (bus.init_in_h && (state_q != StIdle)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            abort_d = 1'b1;
        end
    end

    // The hold count in DROP only starts once the slave has released SSYN.
    assign timer_clr = (state_d != state_q) ||
                       ((state_q == StDrop) && bus.ssyn_in_h && !err_q);

    npr_timer #(
        .DESKEW  (DESKEW),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk         (CLOCK),
        .rst_n       (RESET),
        .clear       (timer_clr),
        .deskew_hit  (deskew_hit),
        .timeout_hit (timeout_hit)
    );

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            addr_q  <= '0;
            c_q     <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            c_q     <= c_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    assign bus.npr_out_h  = (state_q == StReq);
    assign bus.sack_out_h = (state_q == StGrant);
    assign bus.bbsy_out_h = on_bus;
    assign bus.msyn_out_h = (state_q == StMsyn) || (state_q == StLatch);
    assign bus.a_out_h    = on_bus ? bus_addr(addr_q, c_q) : '0;
    assign bus.c_out_h    = on_bus ? bus_cycle(c_q) : '0;
    assign bus.d_out_h    = (on_bus && is_write) ? wdata_q : '0;

    always_comb begin
        armrdata = RD_UNMAPPED;
        case (armraddr)
            REG_ID:   armrdata = IDVER;
            REG_CSR:  armrdata = {busy_q, done_q, err_q, abort_q, 8'h00, c_q, addr_q};
            REG_DATA: armrdata = {rdata_q, wdata_q};
            default:  armrdata = RD_UNMAPPED;
        endcase
    end

endmodule

// File: tb/tb_rl11_npr_master.sv
// Self-checking bench for rl11_npr_master: a Unibus arbiter/memory responder plus
// a word-level memory model that predicts read data and memory contents.
module tb_rl11_npr_master;
    import rl11_npr_pkg::*;

    localparam int unsigned DESKEW  = 15;
    localparam int unsigned TIMEOUT = 1000;
    localparam logic [31:0] IDVER   = 32'h444D2001;

    logic        clk;
    logic        rst_n;
    logic        armwrite;
    logic [2:0]  armraddr;
    logic [2:0]  armwaddr;
    logic [31:0] armwdata;
    logic [31:0] armrdata;

    rl11_npr_master_if bus ();

    rl11_npr_master #(
        .DESKEW  (DESKEW),
        .TIMEOUT (TIMEOUT),
        .IDVER   (IDVER)
    ) dut (
        .CLOCK    (clk),
        .RESET    (rst_n),
        .armwrite (armwrite),
        .armraddr (armraddr),
        .armwaddr (armwaddr),
        .armwdata (armwdata),
        .armrdata (armrdata),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Responder controls and observations.
    bit          grant_en = 1'b1;
    int          grant_delay = 0;
    int          ssyn_delay = 0;
    logic [15:0] mem     [1024];
    logic [15:0] ref_mem [1024];
    logic [17:0] seen_a;
    logic [1:0]  seen_c;
    logic [15:0] seen_d;

    // Monitor observations.
    int          setup_seen = 0;
    int          hold_seen = 0;
    int          msyn_len = 0;
    int          npr_len = 0;
    bit          bbsy_seen = 1'b0;
    logic [17:0] msyn_a = '0;
    logic [1:0]  msyn_c = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arm_wr(input logic [2:0] a, input logic [31:0] d);
        armwaddr = a;
        armwdata = d;
        armwrite = 1'b1;
        @(posedge clk);
        #1;
        armwrite = 1'b0;
    endtask

    task automatic arm_rd(input logic [2:0] a, output logic [31:0] d);
        armraddr = a;
        #1;
        d = armrdata;
    endtask

    task automatic wait_done(output logic [31:0] st);
        for (int i = 0; i < 4000; i++) begin
            arm_rd(REG_CSR, st);
            if (st[30]) return;
            tick(1);
        end
        check_eq("done_wait", {31'b0, st[30]}, 32'd1);
    endtask

    task automatic check_bus_idle(input string tag);
        check_eq({tag, "_ctl"}, {bus.npr_out_h, bus.sack_out_h, bus.bbsy_out_h,
                                 bus.msyn_out_h, bus.c_out_h}, 32'd0);
        check_eq({tag, "_a"}, {14'b0, bus.a_out_h}, 32'd0);
        check_eq({tag, "_d"}, {16'b0, bus.d_out_h}, 32'd0);
    endtask

    // One full transfer, checked against the memory model.
    task automatic run_xfer(input string tag, input logic [17:0] addr, input logic [1:0] c,
                            input logic [15:0] wd);
        logic [31:0] st, r2;
        logic [17:0] ea;
        logic [1:0]  ec;
        logic [9:0]  idx;
        bit          wr;
        ea  = (c == 2'b11) ? addr : {addr[17:1], 1'b0};
        ec  = c[1] ? c : 2'b00;
        wr  = c[1];
        idx = ea[10:1];
        if (wr) begin
            if (c == 2'b11) begin
                ref_mem[idx] = ea[0] ? {wd[15:8], ref_mem[idx][7:0]}
                                     : {ref_mem[idx][15:8], wd[7:0]};
            end else begin
                ref_mem[idx] = wd;
            end
        end
        seen_a = '1;
        seen_c = 2'b01;
        seen_d = ~wd;
        arm_wr(REG_DATA, {16'h0, wd});
        arm_wr(REG_CSR, {1'b1, 11'b0, c, addr});
        wait_done(st);
        check_eq({tag, "_status"}, {28'b0, st[31:28]}, 32'h4);
        check_eq({tag, "_addr"}, {14'b0, seen_a}, {14'b0, ea});
        check_eq({tag, "_cyc"}, {30'b0, seen_c}, {30'b0, ec});
        check_eq({tag, "_setup"}, {31'b0, setup_seen >= int'(DESKEW)}, 32'd1);
        check_eq({tag, "_hold"}, {31'b0, hold_seen >= int'(DESKEW)}, 32'd1);
        if (wr) begin
            check_eq({tag, "_wdata"}, {16'b0, seen_d}, {16'b0, wd});
            check_eq({tag, "_mem"}, {16'b0, mem[idx]}, {16'b0, ref_mem[idx]});
        end else begin
            arm_rd(REG_DATA, r2);
            check_eq({tag, "_rdata"}, {16'b0, r2[31:16]}, {16'b0, ref_mem[idx]});
        end
        tick(1);
    endtask

    // Arbiter and memory slave; addresses with a[17:16]==3 are nonexistent.
    initial begin : responder
        int gcnt;
        int scnt;
        logic [9:0] idx;
        gcnt = 0;
        scnt = 0;
        bus.npg_in_h  = 1'b0;
        bus.ssyn_in_h = 1'b0;
        bus.d_in_h    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.npr_out_h && grant_en) begin
                if (gcnt >= grant_delay) bus.npg_in_h = 1'b1;
                else gcnt++;
            end else begin
                bus.npg_in_h = 1'b0;
                gcnt = 0;
            end
            if (bus.msyn_out_h) begin
                if (!bus.ssyn_in_h && bus.a_out_h[17:16] != 2'b11) begin
                    if (scnt >= ssyn_delay) begin
                        seen_a = bus.a_out_h;
                        seen_c = bus.c_out_h;
                        seen_d = bus.d_out_h;
                        idx    = bus.a_out_h[10:1];
                        case (bus.c_out_h)
                            2'b10: mem[idx] = bus.d_out_h;
                            2'b11: begin
                                if (bus.a_out_h[0]) mem[idx][15:8] = bus.d_out_h[15:8];
                                else mem[idx][7:0] = bus.d_out_h[7:0];
                            end
                            default: bus.d_in_h = mem[idx];
                        endcase
                        bus.ssyn_in_h = 1'b1;
                    end else begin
                        scnt++;
                    end
                end
            end else begin
                bus.ssyn_in_h = 1'b0;
                bus.d_in_h    = '0;
                scnt = 0;
            end
        end
    end

    // Measures bus timing relationships cycle by cycle.
    initial begin : monitor
        bit prev_bbsy;
        bit prev_msyn;
        bit prev_npr;
        int since_bbsy;
        int since_drop;
        prev_bbsy = 1'b0;
        prev_msyn = 1'b0;
        prev_npr  = 1'b0;
        since_bbsy = 0;
        since_drop = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.bbsy_out_h) bbsy_seen = 1'b1;
            if (bus.bbsy_out_h && !prev_bbsy) since_bbsy = 0;
            else since_bbsy++;
            if (bus.msyn_out_h && !prev_msyn) begin
                setup_seen = since_bbsy;
                msyn_a     = bus.a_out_h;
                msyn_c     = bus.c_out_h;
                msyn_len   = 1;
            end else if (bus.msyn_out_h) begin
                msyn_len++;
            end
            if (!bus.msyn_out_h && prev_msyn) since_drop = 0;
            else since_drop++;
            if (!bus.bbsy_out_h && prev_bbsy) hold_seen = since_drop;
            if (bus.npr_out_h && !prev_npr) npr_len = 1;
            else if (bus.npr_out_h) npr_len++;
            prev_bbsy = bus.bbsy_out_h;
            prev_msyn = bus.msyn_out_h;
            prev_npr  = bus.npr_out_h;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] st;
        logic [17:0] ra;
        logic [1:0]  rc;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        rst_n         = 1'b0;
        armwrite      = 1'b0;
        armraddr      = '0;
        armwaddr      = '0;
        armwdata      = '0;
        bus.init_in_h = 1'b0;
        bus.bbsy_in_h = 1'b0;
        tick(3);

        check_bus_idle("reset");
        arm_rd(REG_ID, st);
        check_eq("reset_id", st, IDVER);
        arm_rd(REG_CSR, st);
        check_eq("reset_csr", st, 32'h0);
        arm_rd(REG_DATA, st);
        check_eq("reset_data", st, 32'h0);
        rst_n = 1'b1;
        tick(1);
        arm_rd(3'd3, st);
        check_eq("unmapped_3", st, 32'hDEADBEEF);
        arm_rd(3'd7, st);
        check_eq("unmapped_7", st, 32'hDEADBEEF);

        // Load without start: fields read back, no bus activity.
        arm_wr(REG_CSR, 32'h0005_2345);
        arm_rd(REG_CSR, st);
        check_eq("load_only", st, 32'h0005_2345);
        tick(2);
        check_eq("load_only_npr", {31'b0, bus.npr_out_h}, 32'd0);

        // Directed DATI from 010000 returning 123456.
        grant_delay = 5;
        ssyn_delay  = 3;
        mem[18'o010000 >> 1 & 18'h3FF]     = 16'o123456;
        ref_mem[18'o010000 >> 1 & 18'h3FF] = 16'o123456;
        run_xfer("dati", 18'o010000, 2'b00, 16'h0000);
        arm_rd(REG_DATA, st);
        check_eq("dati_value", {16'b0, st[31:16]}, {16'b0, 16'o123456});

        // Directed DATO via the exact register word.
        run_xfer("dato", 18'o020000, 2'b10, 16'hBEEF);
        arm_rd(REG_CSR, st);
        check_eq("dato_csr_fields", {12'b0, st[19:0]}, 32'h0008_2000);

        // DATOB to an odd byte keeps address bit 0.
        run_xfer("datob", 18'o020001, 2'b11, 16'hA55A);
        check_eq("datob_a0", {31'b0, msyn_a[0]}, 32'd1);
        check_eq("datob_c", {30'b0, msyn_c}, 32'd3);

        // Randomized transfers.
        for (int n = 0; n < 24; n++) begin
            ra = 18'($urandom_range(0, 18'o577777));
            rc = 2'($urandom_range(0, 3));
            grant_delay = $urandom_range(0, 6);
            ssyn_delay  = $urandom_range(0, 5);
            run_xfer($sformatf("rnd%0d", n), ra, rc, 16'($urandom));
        end

        // No SSYN: nonexistent address times out in MSYN.
        grant_delay = 1;
        ssyn_delay  = 0;
        arm_wr(REG_CSR, {1'b1, 11'b0, 2'b00, 18'o600000});
        wait_done(st);
        check_eq("nxm_status", {28'b0, st[31:28]}, 32'h6);
        check_eq("nxm_msyn_min", {31'b0, msyn_len >= int'(TIMEOUT)}, 32'd1);
        check_eq("nxm_msyn_max", {31'b0, msyn_len <= int'(TIMEOUT) + 2}, 32'd1);
        check_bus_idle("nxm_idle");

        // No grant: request times out without ever taking the bus.
        grant_en  = 1'b0;
        bbsy_seen = 1'b0;
        arm_wr(REG_CSR, {1'b1, 11'b0, 2'b00, 18'o001000});
        wait_done(st);
        check_eq("nogrant_status", {28'b0, st[31:28]}, 32'h6);
        check_eq("nogrant_npr", {31'b0, bus.npr_out_h}, 32'd0);
        check_eq("nogrant_bbsy", {31'b0, bbsy_seen}, 32'd0);
        check_eq("nogrant_len", {31'b0, npr_len >= int'(TIMEOUT) && npr_len <= int'(TIMEOUT) + 2},
                 32'd1);
        grant_en = 1'b1;

        // INIT during MSYN aborts; a start while busy is ignored.
        grant_delay = 0;
        ssyn_delay  = 5000;
        arm_wr(REG_CSR, 32'h8000_0400);
        for (int i = 0; i < 200; i++) begin
            if (bus.msyn_out_h) break;
            tick(1);
        end
        check_eq("init_reach_msyn", {31'b0, bus.msyn_out_h}, 32'd1);
        arm_wr(REG_CSR, 32'h8000_3000);
        arm_rd(REG_CSR, st);
        check_eq("busy_ignore_addr", {14'b0, st[17:0]}, 32'h0400);
        check_eq("busy_ignore_busy", {31'b0, st[31]}, 32'd1);
        bus.init_in_h = 1'b1;
        tick(1);
        bus.init_in_h = 1'b0;
        check_bus_idle("init_abort");
        arm_rd(REG_CSR, st);
        check_eq("init_status", {28'b0, st[31:28]}, 32'h5);
        tick(3);

        // INIT while idle leaves status alone.
        bus.init_in_h = 1'b1;
        tick(1);
        bus.init_in_h = 1'b0;
        arm_rd(REG_CSR, st);
        check_eq("init_idle_status", {28'b0, st[31:28]}, 32'h5);

        // INIT together with a start: the start is dropped.
        bus.init_in_h = 1'b1;
        arm_wr(REG_CSR, 32'h8000_0800);
        bus.init_in_h = 1'b0;
        tick(2);
        arm_rd(REG_CSR, st);
        check_eq("init_start_busy", {31'b0, st[31]}, 32'd0);
        check_eq("init_start_npr", {31'b0, bus.npr_out_h}, 32'd0);

        // Bus still usable afterwards.
        ssyn_delay = 2;
        run_xfer("post_init", 18'o000102, 2'b01, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rl11_npr_master.md
Name: rl11_npr_master

Overview:
- Unibus NPR (DMA) bus master that moves data for the RL11 disk path.
- The ARM-side disk emulator reads RLBA/RLDA/RLMP from the RL11 register block, then drives this block one transfer at a time.
- Each transfer requests the bus (NPR), takes grant (SACK/BBSY), runs one DATI, DATO or DATOB cycle, and releases the bus.
- Completion, read data and timeout status are returned through ARM registers.

Parameters:
- DESKEW, 15, clocks between driving A/C/D and asserting MSYN (also MSYN-drop to BBSY-drop hold).
- TIMEOUT, 1000, clocks to wait for SSYN after MSYN, or for NPG after NPR, before declaring error.
- IDVER, 32'h444D2001, constant returned at ARM register 0.

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- armwrite  in  1  ARM register write strobe
- armraddr  in  3  ARM read register select
- armwaddr  in  3  ARM write register select
- armwdata  in  32  ARM write data
- armrdata  out  32  ARM read data (combinational from armraddr)
- init_in_h  in  1  Unibus INIT
- npg_in_h  in  1  NPR grant to this device
- bbsy_in_h  in  1  bus busy (any master)
- ssyn_in_h  in  1  slave sync
- d_in_h  in  16  Unibus data in
- npr_out_h  out  1  NPR request
- sack_out_h  out  1  selection acknowledge
- bbsy_out_h  out  1  bus busy driven by us
- msyn_out_h  out  1  master sync
- a_out_h  out  18  address
- c_out_h  out  2  cycle code
- d_out_h  out  16  write data (zero when not in a DATO/DATOB data phase)

Behaviour:
- Reset (RESET low): all bus outputs 0, state IDLE, busy=done=err=abort=0, addr=0, c=0, wdata=rdata=0.
- ARM reg 0 read: IDVER.
- ARM reg 1 read: [31] busy, [30] done, [29] timeout err, [28] aborted, [19:18] c, [17:00] addr.
- ARM reg 1 write, not busy: load addr=[17:00], c=[19:18], clear done/err/abort. If [31]=1, set busy and enter REQ next clock.
- ARM reg 1 write while busy: ignored entirely.
- ARM reg 2 write: wdata=[15:00] (ignored while busy). Reg 2 read: {rdata, wdata}. Other registers read 32'hDEADBEEF.
- c encoding: 00 DATI, 10 DATO, 11 DATOB; 01 (DATIP) is treated as DATI.
- States:
  - IDLE.
  - REQ: npr_out_h=1, timer counts; npg_in_h -> GRANT; timer==TIMEOUT -> FINISH with err.
  - GRANT: sack_out_h=1, npr_out_h=0; wait until npg_in_h=0, bbsy_in_h=0 and ssyn_in_h=0 -> ADDR.
  - ADDR: bbsy_out_h=1, sack_out_h drops; drive a_out_h=addr, c_out_h=c, d_out_h=wdata if DATO/DATOB; count DESKEW -> MSYN.
  - MSYN: msyn_out_h=1; ssyn_in_h -> LATCH (rdata<=d_in_h for DATI); timer==TIMEOUT -> DROP with err.
  - LATCH: one clock.
  - DROP: msyn_out_h=0; wait ssyn_in_h=0 (or timeout already flagged); count DESKEW -> FINISH.
  - FINISH: bbsy_out_h=0, a/c/d outputs=0, busy=0, done=1 -> IDLE.
- Timer: 16-bit, cleared on every state entry, saturates.
- DATI latency with an immediate grant and SSYN: about 2*DESKEW+6 clocks, start to done.
- init_in_h in any non-IDLE state: next clock all bus outputs 0, busy=0, done=1, abort=1, state IDLE.
- init_in_h in IDLE: no effect on status.
- init_in_h and an ARM start in the same clock: init wins and the start is dropped.
- Addresses wrap naturally; there is no auto-increment. Address bit 0 is passed through for DATOB and masked to 0 for DATI/DATO.

Decomposition:
- Package rl11_npr_pkg: state enumeration, cycle-code constants (C_DATI, C_DATO, C_DATOB), IDVER default, ARM register index constants.
- One natural sub-module, npr_timer: loadable saturating counter with DESKEW/TIMEOUT compare outputs. The remainder stays in one module.

Test Plan:
- DATI: reg1 <= 0x8000_1000 (addr 010000); bench grants NPG after 5 clocks and returns SSYN with d=0o123456 after 3 clocks. Required: reg2[31:16]=0o123456, reg1 done=1, err=0, MSYN asserted ≥DESKEW clocks after address valid.
- DATO: wdata 0xBEEF, reg1 <= 0x8008_2000. Required: bench memory sees a=0o020000, c=10, d=0xBEEF; BBSY held ≥DESKEW clocks after MSYN drop.
- DATOB odd byte: addr 0o020001, c=11. Required: a_out_h bit0=1 and c_out_h=11 during MSYN.
- No SSYN: start DATI to a nonexistent address. Required: err=1 after TIMEOUT clocks in MSYN, bus released, busy=0.
- No grant: NPG never asserted. Required: err=1 after TIMEOUT clocks, npr_out_h=0, bbsy_out_h never asserted.
- init_in_h pulsed during the MSYN state: all bus outputs 0 next clock, abort=1; a second start while busy is ignored (addr unchanged).
